// File: rtl/stage_if_mt.sv
// stage_if_mt -- multithreaded instruction-fetch stage.
//
// Holds one PC per hardware thread and issues one fetch per cycle. A
// round-robin scheduler skips stalled, waiting and redirected threads. The
// selected PC goes out to the I-TLB. The returned physical address is looked
// up in a direct-mapped I-cache, and misses go to a single-outstanding refill
// engine. Results are placed in the IF/ID register, which uses a valid/ready
// handshake.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   redirect_*               overwrite one thread's PC at the next edge
//   thread_stall             per-thread stall from later stages
//   itlb_vaddr/paddr/miss    same-cycle address translation
//   mem_req_*                line-refill request (valid/ready)
//   mem_rsp_*                refill data, tagged with its line address
//   id_valid/id_ready/id_*   IF/ID register and handshake
//   thread_waiting           threads blocked on an outstanding refill
//
// Refill engine states
//   state   | meaning
//   ST_IDLE | no refill outstanding, a cache miss may start one
//   ST_REQ  | request presented, waiting for mem_req_ready
//   ST_WAIT | request accepted, waiting for the matching response
module stage_if_mt #(
    parameter int N_THREADS  = 4,
    parameter int VADDR_W    = 32,
    parameter int PADDR_W    = 20,
    parameter int LINES      = 4,
    parameter int LINE_BYTES = 16,
    parameter logic [VADDR_W-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_en,
    input  logic [$clog2(N_THREADS)-1:0]  redirect_thread,
    input  logic [VADDR_W-1:0]            redirect_pc,
    input  logic [N_THREADS-1:0]          thread_stall,
    output logic [VADDR_W-1:0]            itlb_vaddr,
    input  logic [PADDR_W-1:0]            itlb_paddr,
    input  logic                          itlb_miss,
    output logic                          mem_req_valid,
    output logic [PADDR_W-1:0]            mem_req_addr,
    input  logic                          mem_req_ready,
    input  logic                          mem_rsp_valid,
    input  logic [PADDR_W-1:0]            mem_rsp_addr,
    input  logic [8*LINE_BYTES-1:0]       mem_rsp_line,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [VADDR_W-1:0]            id_pc,
    output logic [31:0]                   id_instruction,
    output logic [$clog2(N_THREADS)-1:0]  id_thread,
    output logic                          id_itlb_miss,
    output logic [N_THREADS-1:0]          thread_waiting
);

    localparam int TW     = $clog2(N_THREADS);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = PADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WORDS  = LINE_BYTES / 4;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} fill_state_t;

    fill_state_t             state_q, state_d;
    logic [VADDR_W-1:0]      pc_q [N_THREADS];
    logic [VADDR_W-1:0]      pc_d [N_THREADS];
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [TAG_W-1:0]        tag_d [LINES];
    logic [LINE_W-1:0]       data_q [LINES];
    logic [LINE_W-1:0]       data_d [LINES];
    logic [PADDR_W-1:0]      req_addr_q, req_addr_d;
    logic [TW-1:0]           req_thread_q, req_thread_d;
    logic [TW-1:0]           last_q, last_d;
    logic [N_THREADS-1:0]    waiting_q, waiting_d;
    logic                    id_valid_q, id_valid_d;
    logic [VADDR_W-1:0]      id_pc_q, id_pc_d;
    logic [31:0]             id_instr_q, id_instr_d;
    logic [TW-1:0]           id_thread_q, id_thread_d;
    logic                    id_miss_q, id_miss_d;

    logic [N_THREADS-1:0]    eligible;
    logic                    slot_free;
    logic                    sel_found;
    logic                    sel_valid;
    logic [TW-1:0]           sel_thread;
    logic [IDX_W-1:0]        lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic [OFF_W-1:0]        lk_word;
    logic                    lk_hit;
    logic [31:0]             lk_instr;
    logic                    fill;
    logic [IDX_W-1:0]        fill_idx;

    assign slot_free  = !id_valid_q || id_ready;
    assign itlb_vaddr = pc_q[sel_thread];

    assign lk_idx   = itlb_paddr[OFF_W +: IDX_W];
    assign lk_tag   = itlb_paddr[PADDR_W-1 -: TAG_W];
    assign lk_word  = itlb_paddr[OFF_W-1:0] >> 2;
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign fill     = (state_q == ST_WAIT) && mem_rsp_valid && (mem_rsp_addr == req_addr_q);
    assign fill_idx = req_addr_q[OFF_W +: IDX_W];

    always_comb begin
        eligible   = '0;
        sel_found  = 1'b0;
        sel_thread = '0;
        lk_instr   = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            eligible[i] = !thread_stall[i] && !waiting_q[i]
                          && !(redirect_en && (redirect_thread == TW'(i)));
        end
        // Search starts just after last_q. The index wraps naturally because
        // N_THREADS is a power of two.
        for (int k = 1; k <= N_THREADS; k++) begin
            if (!sel_found && eligible[last_q + TW'(k)]) begin
                sel_found  = 1'b1;
                sel_thread = last_q + TW'(k);
            end
        end
        for (int w = 0; w < WORDS; w++) begin
            if (lk_word == OFF_W'(w)) lk_instr = data_q[lk_idx][32*w +: 32];
        end
    end

    assign sel_valid = slot_free && sel_found;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        req_addr_d   = req_addr_q;
        req_thread_d = req_thread_q;
        last_d       = last_q;
        waiting_d    = waiting_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_thread_d  = id_thread_q;
        id_miss_d    = id_miss_q;

        if (slot_free) id_valid_d = 1'b0;

        if (sel_valid) begin
            last_d = sel_thread;
            if (itlb_miss) begin
                id_valid_d  = 1'b1;
                id_pc_d     = pc_q[sel_thread];
                id_instr_d  = '0;
                id_thread_d = sel_thread;
                id_miss_d   = 1'b1;
            end else if (lk_hit) begin
                id_valid_d  = 1'b1;
                id_pc_d     = pc_q[sel_thread];
                id_instr_d  = lk_instr;
                id_thread_d = sel_thread;
                id_miss_d   = 1'b0;
                pc_d[sel_thread] = pc_q[sel_thread] + VADDR_W'(4);
            end else if (state_q == ST_IDLE) begin
                waiting_d[sel_thread] = 1'b1;
                req_addr_d   = {itlb_paddr[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                req_thread_d = sel_thread;
                state_d      = ST_REQ;
            end
            // A miss while the engine is busy just replays on a later turn.
        end

        case (state_q)
            ST_REQ: begin
                if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fill) begin
                    valid_d[fill_idx] = 1'b1;
                    tag_d[fill_idx]   = req_addr_q[PADDR_W-1 -: TAG_W];
                    data_d[fill_idx]  = mem_rsp_line;
                    waiting_d[req_thread_q] = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // Redirect wins over the increment. It never cancels an outstanding refill.
        if (redirect_en) pc_d[redirect_thread] = redirect_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < N_THREADS; i++) pc_q[i] <= RESET_PC;
            valid_q      <= '0;
            for (int l = 0; l < LINES; l++) begin
                tag_q[l]  <= '0;
                data_q[l] <= '0;
            end
            req_addr_q   <= '0;
            req_thread_q <= '0;
            last_q       <= TW'(N_THREADS - 1);
            waiting_q    <= '0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= '0;
            id_thread_q  <= '0;
            id_miss_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            req_addr_q   <= req_addr_d;
            req_thread_q <= req_thread_d;
            last_q       <= last_d;
            waiting_q    <= waiting_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_thread_q  <= id_thread_d;
            id_miss_q    <= id_miss_d;
        end
    end

    assign mem_req_valid  = (state_q == ST_REQ);
    assign mem_req_addr   = req_addr_q;
    assign thread_waiting = waiting_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_instruction = id_instr_q;
    assign id_thread      = id_thread_q;
    assign id_itlb_miss   = id_miss_q;

endmodule

// File: tb/tb_stage_if_mt.sv
// Directed bench for stage_if_mt with default parameters. The I-TLB is an
// identity map of the low 20 bits. Memory returns lines whose word at byte
// address A is 0xA5000000 | A. Each step drives inputs right after a rising
// edge, and registered outputs are checked 1 ns after the next edge.
module tb_stage_if_mt;

    logic         clk;
    logic         rst;
    logic         redirect_en;
    logic [1:0]   redirect_thread;
    logic [31:0]  redirect_pc;
    logic [3:0]   thread_stall;
    logic [31:0]  itlb_vaddr;
    logic [19:0]  itlb_paddr;
    logic         itlb_miss;
    logic         mem_req_valid;
    logic [19:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [19:0]  mem_rsp_addr;
    logic [127:0] mem_rsp_line;
    logic         id_valid;
    logic         id_ready;
    logic [31:0]  id_pc;
    logic [31:0]  id_instruction;
    logic [1:0]   id_thread;
    logic         id_itlb_miss;
    logic [3:0]   thread_waiting;

    int vectors;
    int miscompares;

    stage_if_mt dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_en    (redirect_en),
        .redirect_thread(redirect_thread),
        .redirect_pc    (redirect_pc),
        .thread_stall   (thread_stall),
        .itlb_vaddr     (itlb_vaddr),
        .itlb_paddr     (itlb_paddr),
        .itlb_miss      (itlb_miss),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_addr   (mem_rsp_addr),
        .mem_rsp_line   (mem_rsp_line),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_thread      (id_thread),
        .id_itlb_miss   (id_itlb_miss),
        .thread_waiting (thread_waiting)
    );

    assign itlb_paddr = (itlb_vaddr[31:20] == 12'h0) ? itlb_vaddr[19:0] : 20'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [19:0] a);
        logic [127:0] l;
        l = '0;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = 32'hA500_0000 | 32'(a + 20'(4*w));
        return l;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [1:0] thr, input logic [31:0] pc,
                            input logic [31:0] ins, input logic miss);
        check({tag, ".valid"}, 64'(id_valid), 64'(1));
        check({tag, ".thread"}, 64'(id_thread), 64'(thr));
        check({tag, ".pc"}, 64'(id_pc), 64'(pc));
        check({tag, ".instr"}, 64'(id_instruction), 64'(ins));
        check({tag, ".itlb_miss"}, 64'(id_itlb_miss), 64'(miss));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        redirect_en = 1'b0;
        redirect_thread = 2'd0;
        redirect_pc = 32'h0;
        thread_stall = 4'b0111;
        itlb_miss = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_addr = 20'h0;
        mem_rsp_line = '0;
        id_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst.id_valid", 64'(id_valid), 64'(0));
        check("rst.id_pc", 64'(id_pc), 64'(0));
        check("rst.id_instr", 64'(id_instruction), 64'(0));
        check("rst.id_thread", 64'(id_thread), 64'(0));
        check("rst.id_itlb_miss", 64'(id_itlb_miss), 64'(0));
        check("rst.req_valid", 64'(mem_req_valid), 64'(0));
        check("rst.req_addr", 64'(mem_req_addr), 64'(0));
        check("rst.waiting", 64'(thread_waiting), 64'(0));
        rst = 1'b1;

        // Preload line 0 through thread 3. The other threads are stalled, so
        // last_issued stays at 3.
        step();
        check("pre.waiting", 64'(thread_waiting), 64'(4'b1000));
        check("pre.req_valid", 64'(mem_req_valid), 64'(1));
        check("pre.req_addr", 64'(mem_req_addr), 64'(0));
        check("pre.id_valid", 64'(id_valid), 64'(0));
        mem_req_ready = 1'b1;
        step();
        check("pre.req_accepted", 64'(mem_req_valid), 64'(0));
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_addr = 20'h0;
        mem_rsp_line = line_of(20'h0);
        step();
        check("pre.filled", 64'(thread_waiting), 64'(0));
        mem_rsp_valid = 1'b0;
        thread_stall = 4'b0000;
        #1;
        check("rr.itlb_vaddr", 64'(itlb_vaddr), 64'(0));

        // All four threads hit at pc 0 in order.
        for (int t = 0; t < 4; t++) begin
            step();
            check_id($sformatf("rr%0d", t), 2'(t), 32'h0, 32'hA500_0000, 1'b0);
        end

        // Redirect thread 1 to 0x40 while thread 0 fetches pc 4.
        redirect_en = 1'b1;
        redirect_thread = 2'd1;
        redirect_pc = 32'h40;
        step();
        check_id("t0pc4", 2'd0, 32'h4, 32'hA500_0004, 1'b0);
        redirect_en = 1'b0;
        #1;
        check("miss.itlb_vaddr", 64'(itlb_vaddr), 64'h40);

        // Thread 1 misses at 0x40. The request is held while ready stays low.
        step();
        check("miss.id_valid", 64'(id_valid), 64'(0));
        check("miss.req_valid", 64'(mem_req_valid), 64'(1));
        check("miss.req_addr", 64'(mem_req_addr), 64'h40);
        check("miss.waiting", 64'(thread_waiting), 64'(4'b0010));
        step();
        check_id("hold1", 2'd2, 32'h4, 32'hA500_0004, 1'b0);
        check("hold1.req_valid", 64'(mem_req_valid), 64'(1));
        check("hold1.waiting", 64'(thread_waiting), 64'(4'b0010));
        step();
        check_id("hold2", 2'd3, 32'h4, 32'hA500_0004, 1'b0);
        check("hold2.req_addr", 64'(mem_req_addr), 64'h40);
        redirect_en = 1'b1;
        redirect_thread = 2'd2;
        redirect_pc = 32'h20;
        step();
        check_id("hold3", 2'd0, 32'h8, 32'hA500_0008, 1'b0);
        check("hold3.req_valid", 64'(mem_req_valid), 64'(1));
        check("hold3.req_addr", 64'(mem_req_addr), 64'h40);
        check("hold3.waiting", 64'(thread_waiting), 64'(4'b0010));

        // Thread 2 misses at 0x20 while the engine is busy, so it replays.
        redirect_en = 1'b0;
        mem_req_ready = 1'b1;
        step();
        check("busy.id_valid", 64'(id_valid), 64'(0));
        check("busy.waiting", 64'(thread_waiting), 64'(4'b0010));
        check("busy.req_valid", 64'(mem_req_valid), 64'(0));
        check("busy.req_addr", 64'(mem_req_addr), 64'h40);

        // A response for the wrong line is ignored.
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_addr = 20'h80;
        mem_rsp_line = line_of(20'h80);
        step();
        check_id("bogus", 2'd3, 32'h8, 32'hA500_0008, 1'b0);
        check("bogus.waiting", 64'(thread_waiting), 64'(4'b0010));
        mem_rsp_valid = 1'b0;
        step();
        check_id("line0_kept", 2'd0, 32'hC, 32'hA500_000C, 1'b0);
        step();
        check("replay.id_valid", 64'(id_valid), 64'(0));
        check("replay.waiting", 64'(thread_waiting), 64'(4'b0010));

        // The matching response fills the line. The same-cycle lookup sees the old line.
        mem_rsp_valid = 1'b1;
        mem_rsp_addr = 20'h40;
        mem_rsp_line = line_of(20'h40);
        step();
        check_id("fill_cycle", 2'd3, 32'hC, 32'hA500_000C, 1'b0);
        check("fill.waiting", 64'(thread_waiting), 64'(0));
        mem_rsp_valid = 1'b0;
        thread_stall = 4'b0001;
        step();
        check_id("t1_0x40", 2'd1, 32'h40, 32'hA500_0040, 1'b0);

        // I-TLB miss on thread 0: the instruction is zero and the pc stays put.
        thread_stall = 4'b1100;
        itlb_miss = 1'b1;
        step();
        check_id("tlbmiss", 2'd0, 32'h10, 32'h0, 1'b1);
        check("tlbmiss.req_valid", 64'(mem_req_valid), 64'(0));
        check("tlbmiss.waiting", 64'(thread_waiting), 64'(0));
        itlb_miss = 1'b0;
        step();
        check_id("t1_0x44", 2'd1, 32'h44, 32'hA500_0044, 1'b0);
        itlb_miss = 1'b1;
        step();
        check_id("tlbmiss_again", 2'd0, 32'h10, 32'h0, 1'b1);
        itlb_miss = 1'b0;
        step();
        check_id("t1_0x48", 2'd1, 32'h48, 32'hA500_0048, 1'b0);

        // Backpressure for three cycles, with a redirect of thread 3 in the window.
        id_ready = 1'b0;
        redirect_en = 1'b1;
        redirect_thread = 2'd3;
        redirect_pc = 32'h100;
        step();
        check_id("bp1", 2'd1, 32'h48, 32'hA500_0048, 1'b0);
        redirect_en = 1'b0;
        step();
        check_id("bp2", 2'd1, 32'h48, 32'hA500_0048, 1'b0);
        step();
        check_id("bp3", 2'd1, 32'h48, 32'hA500_0048, 1'b0);
        id_ready = 1'b1;
        thread_stall = 4'b0101;
        itlb_miss = 1'b1;
        step();
        check_id("t3_redir", 2'd3, 32'h100, 32'h0, 1'b1);
        itlb_miss = 1'b0;
        step();
        check_id("t1_0x4c", 2'd1, 32'h4C, 32'hA500_004C, 1'b0);

        // Reset in the middle of a refill abandons it.
        thread_stall = 4'b0111;
        step();
        check("mid.req_valid", 64'(mem_req_valid), 64'(1));
        check("mid.req_addr", 64'(mem_req_addr), 64'h100);
        check("mid.waiting", 64'(thread_waiting), 64'(4'b1000));
        rst = 1'b0;
        #2;
        check("mid_rst.req_valid", 64'(mem_req_valid), 64'(0));
        check("mid_rst.req_addr", 64'(mem_req_addr), 64'(0));
        check("mid_rst.waiting", 64'(thread_waiting), 64'(0));
        check("mid_rst.id_valid", 64'(id_valid), 64'(0));
        rst = 1'b1;
        thread_stall = 4'b1111;
        mem_rsp_valid = 1'b1;
        mem_rsp_addr = 20'h100;
        mem_rsp_line = line_of(20'h100);
        step();
        check("late_rsp.waiting", 64'(thread_waiting), 64'(0));
        check("late_rsp.req_valid", 64'(mem_req_valid), 64'(0));
        check("late_rsp.id_valid", 64'(id_valid), 64'(0));
        mem_rsp_valid = 1'b0;
        thread_stall = 4'b0111;
        step();
        check("post_rst.req_valid", 64'(mem_req_valid), 64'(1));
        check("post_rst.req_addr", 64'(mem_req_addr), 64'(0));
        check("post_rst.waiting", 64'(thread_waiting), 64'(4'b1000));
        check("post_rst.id_valid", 64'(id_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
